muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes the RD1/RD2 operand pair and returns a result plus destination register for writeback into WD3/A3.
- The control unit stalls the PC while busy is high.
- Fixed-latency, one operation in flight.

---
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operation in flight, fixed latency of
// DATA_WIDTH iterations plus one DONE cycle, registered result and destination index.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    input  logic                     kill,
    output logic                     busy,
    output logic                     valid_out,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] rd_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic n);
        return n ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic n);
        return n ? (~v + {{(2*W-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [2:0]               f_q, f_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
    logic [W-1:0]             addend_q, addend_d;
    logic [2*W-1:0]           acc_q, acc_d;
    logic                     neg_q, neg_d;
    logic                     rneg_q, rneg_d;
    logic [W-1:0]             result_q, result_d;
    logic [ADDRESS_WIDTH-1:0] rd_out_q, rd_out_d;
    logic                     valid_q, valid_d;

    logic                     sign_a_s, sign_b_s, a_neg_s, b_neg_s;
    logic [W-1:0]             a_mag_s, b_mag_s;
    logic [W:0]               mul_sum_s, rem_sh_s, diff_s;
    logic [2*W-1:0]           mul_next_s, div_next_s, prod_s;

    // Operand sign decode and magnitude conversion for the capture cycle
    always_comb begin
        sign_a_s = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_b_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_s  = sign_a_s & op_a[W-1];
        b_neg_s  = sign_b_s & op_b[W-1];
        a_mag_s  = cond_neg(op_a, a_neg_s);
        b_mag_s  = cond_neg(op_b, b_neg_s);
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    // Multiply keeps {product_hi, multiplier}; divide keeps {remainder, quotient}.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, addend_q} : {(W+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_q[W-1:1]};
        rem_sh_s   = acc_q[2*W-1:W-1];
        diff_s     = rem_sh_s - {1'b0, addend_q};
        if (diff_s[W]) begin
            div_next_s = {rem_sh_s[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_next_s = {diff_s[W-1:0], acc_q[W-2:0], 1'b1};
        end
        prod_s = cond_neg2(acc_q, neg_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f_d      = f_q;
        rd_d     = rd_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    f_d   = funct3;
                    rd_d  = rd_in;
                    cnt_d = {CW{1'b0}};
                    if (funct3[2]) begin
                        addend_d = b_mag_s;
                        acc_d    = {{W{1'b0}}, a_mag_s};
                        // A zero divisor must yield all ones, so no quotient sign fix
                        neg_d    = (a_neg_s ^ b_neg_s) & (op_b != {W{1'b0}});
                        rneg_d   = a_neg_s;
                    end else begin
                        addend_d = a_mag_s;
                        acc_d    = {{W{1'b0}}, b_mag_s};
                        neg_d    = a_neg_s ^ b_neg_s;
                        rneg_d   = 1'b0;
                    end
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = f_q[2] ? div_next_s : mul_next_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            DONE: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    case (f_q)
                        3'b000:                 result_d = acc_q[W-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod_s[2*W-1:W];
                        3'b100, 3'b101:         result_d = cond_neg(acc_q[W-1:0], neg_q);
                        3'b110, 3'b111:         result_d = cond_neg(acc_q[2*W-1:W], rneg_q);
                        default:                result_d = result_q;
                    endcase
                    rd_out_d = rd_q;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            f_q      <= 3'b000;
            rd_q     <= {ADDRESS_WIDTH{1'b0}};
            addend_q <= {W{1'b0}};
            acc_q    <= {(2*W){1'b0}};
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= {W{1'b0}};
            rd_out_q <= {ADDRESS_WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f_q      <= f_d;
            rd_q     <= rd_d;
            addend_q <= addend_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            valid_q  <= valid_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign valid_out = valid_q;
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed RV32M results, latency,
// handshake, kill and asynchronous reset behaviour.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy, valid_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .kill(kill),
        .busy(busy), .valid_out(valid_out), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scribble the operand inputs afterwards, and check latency/result
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
        int edges;
        logic seen, busy_ok;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D; rd_in = 5'd31; funct3 = 3'b011;
        edges = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (valid_out) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check_eq({tag, "_latency"}, edges, 32'd33);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        check_eq({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, {31'd0, valid_out}, 32'd0);
    endtask

    initial begin
        int edges, pulses;
        logic [31:0] prev;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'b000;
        op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_rd", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF);
        do_op("divu",   3'b101, 32'd100,       32'd7,         5'd12, 32'd14);
        do_op("remu",   3'b111, 32'd100,       32'd7,         5'd13, 32'd2);
        do_op("divu0",  3'b101, 32'h0000_1234, 32'd0,         5'd14, 32'hFFFF_FFFF);
        do_op("rem0",   3'b110, 32'h0000_1234, 32'd0,         5'd15, 32'h0000_1234);
        do_op("divneg0",3'b100, 32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFFF);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'd0);

        // Second start during CALC must be ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0; pulses = 0;
        while (edges < 34) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 5) begin
                start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd1;
            end
            if (edges == 6) start = 1'b0;
            if (valid_out) begin
                pulses++;
                check_eq("hs_edge", edges, 32'd33);
                check_eq("hs_result", result, 32'd14);
                check_eq("hs_rd", {27'd0, rd_out}, 32'd9);
            end
        end
        check_eq("hs_pulses", pulses, 32'd1);
        do_op("hs_next", 3'b000, 32'd6, 32'd9, 5'd3, 32'd54);

        // Kill mid-calculation: no pulse, result retained
        prev = 32'd54;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd11; rd_in = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check_eq("kill_busy", {31'd0, busy}, 32'd0);
        check_eq("kill_valid", {31'd0, valid_out}, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
        end
        check_eq("kill_pulses", pulses, 32'd0);
        check_eq("kill_result", result, prev);
        check_eq("kill_rd", {27'd0, rd_out}, 32'd3);
        do_op("kill_next", 3'b101, 32'd1000, 32'd10, 5'd2, 32'd100);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("arst_result", result, 32'd0);
        check_eq("arst_rd", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
        end
        check_eq("arst_pulses", pulses, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
